// File: rtl/shift_control_unit_if.sv
// Command/status bundle between the button synchronisers and the shift sequencer.
// Step only exists when SINGLE_STEP_EN is defined.
interface shift_control_unit_if #(
  parameter int CNT_W = 8
);
  logic             Execute;
  logic             LoadA;
  logic             LoadB;
`ifdef SINGLE_STEP_EN
  logic             Step;
`endif
  logic             Ld_A;
  logic             Ld_B;
  logic             Shift_En;
  logic             Busy;
  logic             Done;
  logic [CNT_W-1:0] Shift_Cnt;

  modport master (
    output Execute, LoadA, LoadB,
`ifdef SINGLE_STEP_EN
    output Step,
`endif
    input  Ld_A, Ld_B, Shift_En, Busy, Done, Shift_Cnt
  );

  modport slave (
    input  Execute, LoadA, LoadB,
`ifdef SINGLE_STEP_EN
    input  Step,
`endif
    output Ld_A, Ld_B, Shift_En, Busy, Done, Shift_Cnt
  );
endinterface

// File: rtl/shift_control_unit.sv
// Sequencer turning Execute/LoadA/LoadB levels into load strobes and an N_SHIFTS shift burst.
// Optional SINGLE_STEP_EN: each shift in RUN waits for a rising edge on Step.
module shift_control_unit #(
  parameter int N_SHIFTS = 8,
  parameter int CNT_W    = 8
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset_n,
  shift_control_unit_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LDWAIT,
    S_RUN,
    S_DONE,
    S_HOLD
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(N_SHIFTS - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_sel_a;
  logic             r_sel_b;
  logic             w_adv;

`ifdef SINGLE_STEP_EN
  logic r_step_d;
  logic r_step_go;

  // r_step_go is high for exactly the cycle after a Step rising edge.
  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      r_step_d  <= 1'b0;
      r_step_go <= 1'b0;
    end else begin
      r_step_d  <= bus.Step;
      r_step_go <= bus.Step & ~r_step_d;
    end
  end

  assign w_adv = r_step_go;
`else
  assign w_adv = 1'b1;
`endif

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sel_a <= 1'b0;
      r_sel_b <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_next == S_LOAD) begin
        r_sel_a <= bus.LoadA;
        r_sel_b <= bus.LoadB;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.Execute) begin
          w_next     = S_RUN;
          w_cnt_next = '0;
        end else if (bus.LoadA || bus.LoadB) begin
          w_next = S_LOAD;
        end
      end
      S_LOAD:   w_next = S_LDWAIT;
      S_LDWAIT: if (!bus.LoadA && !bus.LoadB) w_next = S_IDLE;
      S_RUN: begin
        if (w_adv) begin
          w_cnt_next = r_cnt + CNT_W'(1);
          if (r_cnt == LP_LAST) w_next = S_DONE;
        end
      end
      // A still-held Execute parks in HOLD so it cannot start a second burst.
      S_DONE:   w_next = bus.Execute ? S_HOLD : S_IDLE;
      S_HOLD:   if (!bus.Execute) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.Ld_A      = (r_state == S_LOAD) && r_sel_a;
    bus.Ld_B      = (r_state == S_LOAD) && r_sel_b;
    bus.Shift_En  = (r_state == S_RUN) && w_adv;
    bus.Busy      = (r_state == S_RUN) || (r_state == S_DONE) || (r_state == S_HOLD);
    bus.Done      = (r_state == S_DONE);
    bus.Shift_Cnt = r_cnt;
  end

endmodule

// File: tb/tb_shift_control_unit.sv
// Randomised scoreboard bench: stimulus tasks predict every strobe/shift/done cycle, a monitor compares.
// Cycle numbering: cycle c lies between rising edge c and c+1.
module tb_shift_control_unit;

  localparam int NS = 8;
  localparam int CW = 8;

  typedef struct {
    int         cyc;
    logic       ld_a;
    logic       ld_b;
    logic       sh;
    logic       dn;
    logic       bz;
    logic [7:0] cnt;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  bit   step_mode = 1'b0;
  int   last_cnt = 0;
  int   s_cyc[NS];
  ev_t  exp_q[$];

  shift_control_unit_if #(.CNT_W(CW)) sif ();

  shift_control_unit #(.N_SHIFTS(NS), .CNT_W(CW)) dut (
    .i_Clk     (clk),
    .i_Reset_n (rst_n),
    .bus       (sif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input bit a, input bit b, input bit sh, input bit dn,
                      input bit bz, input int cnt);
    ev_t e;
    e.cyc = c; e.ld_a = a; e.ld_b = b; e.sh = sh; e.dn = dn; e.bz = bz; e.cnt = 8'(cnt);
    exp_q.push_back(e);
  endtask

  task automatic clear_inputs();
    sif.Execute = 1'b0;
    sif.LoadA   = 1'b0;
    sif.LoadB   = 1'b0;
`ifdef SINGLE_STEP_EN
    sif.Step    = 1'b0;
`endif
  endtask

  // Sets inputs that will be sampled at edge t of an Execute press sampled first at edge k.
  task automatic drive(input int t, input int k, input int hold, input bit noise);
    sif.Execute = (t >= k) && (t < k + hold);
    sif.LoadA   = noise && (t >= k + 2) && (t <= k + 3);
`ifdef SINGLE_STEP_EN
    sif.Step = 1'b0;
    for (int i = 0; i < NS; i++)
      if (t == s_cyc[i]) sif.Step = 1'b1;
`endif
  endtask

  // Monitor: any cycle showing a strobe, shift or done must match the next predicted event.
  always @(negedge clk) begin
    if (mon_en && (sif.Ld_A || sif.Ld_B || sif.Shift_En || sif.Done)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d got ld_a=%b ld_b=%b sh=%b dn=%b busy=%b cnt=%0d expected none",
                 cyc, sif.Ld_A, sif.Ld_B, sif.Shift_En, sif.Done, sif.Busy, sif.Shift_Cnt);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (e.cyc != cyc ||
            {sif.Ld_A, sif.Ld_B, sif.Shift_En, sif.Done, sif.Busy, sif.Shift_Cnt} !==
            {e.ld_a, e.ld_b, e.sh, e.dn, e.bz, e.cnt}) begin
          errors++;
          $display("FAIL event: got cyc=%0d ld_a=%b ld_b=%b sh=%b dn=%b busy=%b cnt=%0d expected cyc=%0d ld_a=%b ld_b=%b sh=%b dn=%b busy=%b cnt=%0d",
                   cyc, sif.Ld_A, sif.Ld_B, sif.Shift_En, sif.Done, sif.Busy, sif.Shift_Cnt,
                   e.cyc, e.ld_a, e.ld_b, e.sh, e.dn, e.bz, e.cnt);
        end
      end
    end
  end

  // One press of LoadA/LoadB held for 'hold' edges; optionally pokes Execute while waiting for release.
  task automatic do_load(input bit a, input bit b, input int hold, input bit exec_in_wait);
    int k;
    tick();
    sif.LoadA = a;
    sif.LoadB = b;
    k = cyc + 1;
    push(k, a, b, 1'b0, 1'b0, 1'b0, last_cnt);
    for (int i = 1; i < hold; i++) begin
      tick();
      sif.Execute = exec_in_wait && (i == 2);
    end
    tick();
    clear_inputs();
    while (cyc < k + hold) tick();
    @(negedge clk);
    chk("load_idle_busy", 32'(sif.Busy), 0);
    chk("load_idle_cnt", 32'(sif.Shift_Cnt), 32'(last_cnt));
  endtask

  // One Execute press held for 'hold' edges; noise wiggles LoadA mid-burst; rst_mid resets after 3 shifts.
  task automatic do_exec(input int hold, input bit noise, input bit rst_mid);
    int k, done_c, end_c, rst_e;
    tick();
    k = cyc + 1;
    for (int i = 0; i < NS; i++) s_cyc[i] = step_mode ? k + 2 + 4 * i : k + i;
    drive(cyc + 1, k, hold, noise);
    if (!rst_mid) begin
      for (int i = 0; i < NS; i++) push(s_cyc[i], 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, i);
      done_c = s_cyc[NS-1] + 1;
      push(done_c, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, NS);
      end_c = (done_c + 1 <= k + hold - 1) ? k + hold : done_c + 1;
      while (cyc < end_c - 1) begin
        tick();
        drive(cyc + 1, k, hold, noise);
      end
      @(negedge clk);
      chk("busy_before_idle", 32'(sif.Busy), 1);
      tick();
      drive(cyc + 1, k, hold, noise);
      @(negedge clk);
      chk("idle_busy", 32'(sif.Busy), 0);
      chk("idle_cnt", 32'(sif.Shift_Cnt), NS);
      last_cnt = NS;
    end else begin
      for (int i = 0; i < 3; i++) push(s_cyc[i], 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, i);
      rst_e = s_cyc[2] + 1 + (step_mode ? 1 : 0);
      while (cyc < rst_e - 1) begin
        tick();
        drive(cyc + 1, k, hold, noise);
      end
      if (step_mode) begin
        @(negedge clk);
        chk("step_cnt3", 32'(sif.Shift_Cnt), 3);
        chk("step_busy", 32'(sif.Busy), 1);
        chk("step_gap_sh", 32'(sif.Shift_En), 0);
      end
      rst_n = 1'b0;
      clear_inputs();
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_mid_sh", 32'(sif.Shift_En), 0);
      chk("rst_mid_cnt", 32'(sif.Shift_Cnt), 0);
      chk("rst_mid_busy", 32'(sif.Busy), 0);
      last_cnt = 0;
    end
    clear_inputs();
  endtask

  initial begin
    int op, a, b;
`ifdef SINGLE_STEP_EN
    step_mode = 1'b1;
`endif
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ld_a", 32'(sif.Ld_A), 0);
    chk("rst_ld_b", 32'(sif.Ld_B), 0);
    chk("rst_shift", 32'(sif.Shift_En), 0);
    chk("rst_busy", 32'(sif.Busy), 0);
    chk("rst_done", 32'(sif.Done), 0);
    chk("rst_cnt", 32'(sif.Shift_Cnt), 0);
    mon_en = 1'b1;

    do_load(1'b1, 1'b0, 5, 1'b0);
    do_load(1'b1, 1'b0, 5, 1'b0);
    do_load(1'b1, 1'b1, 4, 1'b1);
    do_exec(20, 1'b0, 1'b0);
    do_exec(1, 1'b0, 1'b0);
    do_exec(40, 1'b0, 1'b1);
    do_exec(3, 1'b1, 1'b0);
    do_load(1'b0, 1'b1, 1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 9);
      if (op < 4) begin
        a = $urandom_range(0, 1);
        b = (a == 0) ? 1 : $urandom_range(0, 1);
        do_load(a[0], b[0], $urandom_range(1, 6), $urandom_range(0, 1) == 1);
      end else if (op < 9) begin
        do_exec($urandom_range(1, step_mode ? 45 : 20), $urandom_range(0, 1) == 1, 1'b0);
      end else begin
        do_exec($urandom_range(1, 20), 1'b0, 1'b1);
      end
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (10) tick();
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_control_unit.md
Name: shift_control_unit

Overview:
- Sequencing FSM that drives the dual 8-bit shift-register unit in the shift-add datapath.
- Converts push-button-level commands (Execute, LoadA, LoadB) into single-cycle load strobes and a burst of exactly N_SHIFTS shift-enable cycles.
- Reports Busy/Done status to the top level.
- Sits between the switch/button synchronisers and the register unit's Ld_A/Ld_B/Shift_En inputs.

Parameters:
- N_SHIFTS, 8, number of consecutive Shift_En cycles per Execute press (legal range 1..255).
- CNT_W, 8, shift-counter width; must satisfy 2^CNT_W > N_SHIFTS.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset_n  input  1  synchronous active-low reset.
- Execute  input  1  level, already synchronised; starts a shift burst.
- LoadA  input  1  level; requests a load of register A.
- LoadB  input  1  level; requests a load of register B.
- Step  input  1  single-step advance (present only with SINGLE_STEP_EN).
- Ld_A  output  1  one-cycle load strobe to register A.
- Ld_B  output  1  one-cycle load strobe to register B.
- Shift_En  output  1  shift enable to both registers.
- Busy  output  1  high in RUN, DONE and HOLD.
- Done  output  1  one-cycle pulse on burst completion.
- Shift_Cnt  output  CNT_W  number of shifts issued in the current burst.

Behaviour:
- Reset: Reset_n sampled low at a rising edge -> state IDLE, counter 0, load latches 0. From the next cycle Ld_A=Ld_B=Shift_En=Busy=Done=0 and Shift_Cnt=0. Reset mid-burst aborts immediately; no further Shift_En.
- All outputs are Moore outputs decoded from registered state, counter and latches. Every output change is visible in the cycle after the causing edge.
- States: IDLE, LOAD, LDWAIT, RUN, DONE, HOLD.
- IDLE:
  - Execute=1 -> RUN, counter cleared. Execute has priority over LoadA/LoadB.
  - Otherwise LoadA|LoadB -> LOAD, latching selA=LoadA and selB=LoadB.
  - Otherwise stay in IDLE.
- LOAD: exactly one cycle, with Ld_A=selA and Ld_B=selB; both strobes are asserted if both were requested. Always -> LDWAIT.
- LDWAIT: stay until LoadA=0 and LoadB=0, then -> IDLE. One strobe per press; Execute is ignored here.
- RUN:
  - Shift_En=1.
  - Counter increments each cycle; Shift_Cnt shows 0..N_SHIFTS-1 during RUN.
  - When counter==N_SHIFTS-1 -> DONE with counter=N_SHIFTS.
  - Execute and Load inputs are ignored, so exactly N_SHIFTS Shift_En cycles are issued.
- DONE: one cycle with Done=1, Shift_En=0, Shift_Cnt=N_SHIFTS.
  - Execute=1 -> HOLD.
  - Execute=0 -> IDLE.
- HOLD: stay while Execute=1, then -> IDLE. A held button never re-triggers a burst.
- Shift_Cnt:
  - Holds N_SHIFTS through HOLD.
  - Cleared on entry to RUN or on reset.
  - Never wraps, because of the CNT_W constraint.
- Latency: Execute rising and sampled at edge k gives Shift_En high for cycles k+1..k+N_SHIFTS and Done high in cycle k+N_SHIFTS+1.
- Simultaneous LoadA and LoadB in IDLE: both strobes are asserted in the same cycle.
- Ld_A, Ld_B and Shift_En are never high in the same cycle.

Optional Feature:
- Macro SINGLE_STEP_EN.
- When defined:
  - Step port exists and is edge-detected internally; a rising edge means Step was 0 in the previous cycle and 1 now.
  - In RUN, Shift_En is asserted and the counter advances only in the cycle following a Step rising edge.
  - Between steps, state remains RUN with Shift_En=0 and Busy=1.
  - The Step edge register resets to 0.
- When undefined: no Step port, behaviour exactly as above.

Test Plan:
- Reset_n=0 for 2 cycles, all inputs 0 -> all outputs 0, Shift_Cnt=0, state IDLE.
- LoadA=1 for 5 cycles -> Ld_A=1 for exactly 1 cycle, Ld_B=0 throughout. After LoadA=0, a second press gives one more strobe.
- LoadA=LoadB=1 in the same cycle -> Ld_A=Ld_B=1 in the same single cycle. Execute=1 during LDWAIT gives no Shift_En.
- Execute=1 held for 20 cycles, N_SHIFTS=8 -> Shift_En high for exactly 8 consecutive cycles, Shift_Cnt 0..7. Then Done=1 for 1 cycle with Shift_Cnt=8, Busy=1 until 1 cycle after Execute falls, no second burst.
- Execute pulse for 1 cycle -> still 8 Shift_En cycles, Done pulse, then IDLE with Busy=0.
- Reset_n=0 after the 3rd Shift_En cycle -> Shift_En=0 from the next cycle, Shift_Cnt=0. A new Execute then yields a full 8-cycle burst.
- With SINGLE_STEP_EN: Execute=1, then 3 Step pulses 4 cycles apart -> exactly 3 Shift_En cycles, each the cycle after a Step rising edge, Shift_Cnt=3, Busy=1.
